qsys_irq_aggregator: RTL and testbench



---
 rtl/qsys_irq_pkg.sv | 40 ++++
 rtl/qsys_irq_prio_enc.sv | 31 +++
 rtl/qsys_irq_aggregator.sv | 202 ++++++++++++++++++++
 tb/tb_qsys_irq_aggregator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qsys_irq_pkg
// Description : Shared constants, types and helpers for the interrupt
//               aggregator: register map, FSM states, VECTOR layout.
// Revision    : 1.0 - initial release
// ============================================================================
package qsys_irq_pkg;

  // Register map (3-bit Avalon-MM word address)
  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_HOLDOFF = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;

  // Width of the winning-source index field
  localparam int IDX_W = 4;

  // Position of the valid flag in the VECTOR read word
  localparam int VECTOR_VALID_BIT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Build the VECTOR read word: {valid, zeros, idx}
  function automatic logic [15:0] vector_word(input logic valid, input logic [IDX_W-1:0] idx);
    logic [15:0] w;
    w = '0;
    w[VECTOR_VALID_BIT] = valid;
    w[IDX_W-1:0]        = idx;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qsys_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : qsys_irq_prio_enc
// Description : Combinational lowest-index-first priority encoder. Bit 0 has
//               the highest priority; idx is 0 when no request is set.
// Revision    : 1.0 - initial release
// ============================================================================
module qsys_irq_prio_enc
  import qsys_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/qsys_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : qsys_irq_aggregator
// Description : Latches, masks and prioritises up to 16 interrupt lines and
//               drives a single registered CPU interrupt. 16-bit Avalon-MM
//               slave with 1-cycle registered read data. A write to VECTOR
//               acknowledges the winning source; an optional holdoff window
//               keeps irq low after an acknowledge.
//               Optional macro QSYS_IRQ_SYNC_EN: adds a 2-flop input
//               synchroniser on irq_in (RAW then reads the synchronised value).
// Revision    : 1.0 - initial release
// ============================================================================
module qsys_irq_aggregator
  import qsys_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  // Elaboration-time parameter guards
  if (DATA_W != 16) begin : g_bad_data_w
    $error("qsys_irq_aggregator: DATA_W must be 16");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
    $error("qsys_irq_aggregator: NUM_IRQ must be in 1..16");
  end

  logic [NUM_IRQ-1:0] s_in;
  logic [NUM_IRQ-1:0] prev_in_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] edge_q;
  logic [15:0]        holdoff_q;
  logic [15:0]        cnt_q;
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               irq_q;
  state_e             state_q;

  logic [NUM_IRQ-1:0] act;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] w1c;
  logic               vec_valid;
  logic [IDX_W-1:0]   vec_idx;
  logic               wr_en;
  logic               ack;

`ifdef QSYS_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser for asynchronous interrupt lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_in = sync2_q;
`else
  assign s_in = irq_in;
`endif

  assign wr_en = chipselect & ~write_n;
  assign act   = pending_q & mask_q;

  qsys_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req_i   (act),
    .valid_o (vec_valid),
    .idx_o   (vec_idx)
  );

  // An acknowledge only counts when a source is actually winning
  assign ack = wr_en && (address == ADDR_VECTOR) && vec_valid;

  // Pending next state: level bits track the line, edge bits latch rising
  // edges and clear on W1C or ACK, with a new edge beating a same-cycle clear
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack && (vec_idx == IDX_W'(i))) begin
        ack_clr[i] = edge_q[i];
      end
    end
    w1c = (wr_en && (address == ADDR_PENDING)) ? writedata[NUM_IRQ-1:0] : '0;
    pending_d = (edge_q & ((s_in & ~prev_in_q) | (pending_q & ~(w1c | ack_clr))))
              | (~edge_q & s_in);
  end

  // Input history and pending latch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_in_q <= '0;
      pending_q <= '0;
    end else begin
      prev_in_q <= s_in;
      pending_q <= pending_d;
    end
  end

  // Configuration registers written over the slave port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      edge_q    <= '0;
      holdoff_q <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_MASK:    mask_q    <= writedata[NUM_IRQ-1:0];
        ADDR_EDGE:    edge_q    <= writedata[NUM_IRQ-1:0];
        ADDR_HOLDOFF: holdoff_q <= writedata;
        default:      ;
      endcase
    end
  end

  // Read mux; unused bits and unmapped addresses read 0
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_PENDING: readdata_d[NUM_IRQ-1:0] = pending_q;
      ADDR_MASK:    readdata_d[NUM_IRQ-1:0] = mask_q;
      ADDR_EDGE:    readdata_d[NUM_IRQ-1:0] = edge_q;
      ADDR_VECTOR:  readdata_d              = vector_word(vec_valid, vec_idx);
      ADDR_HOLDOFF: readdata_d              = holdoff_q;
      ADDR_RAW:     readdata_d[NUM_IRQ-1:0] = s_in;
      default:      readdata_d              = '0;
    endcase
  end

  // Registered read data, refreshed every clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  // Interrupt FSM with registered irq and holdoff counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (act != '0) begin
            state_q <= ASSERT;
            irq_q   <= 1'b1;
          end
        end
        ASSERT: begin
          if (ack) begin
            if (holdoff_q != '0) begin
              state_q <= HOLD;
              irq_q   <= 1'b0;
              cnt_q   <= holdoff_q - 16'd1;
            end else if ((act & ~ack_clr) == '0) begin
              state_q <= IDLE;
              irq_q   <= 1'b0;
            end
          end else if (act == '0) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_qsys_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_qsys_irq_aggregator
// Description : Self-checking bench for qsys_irq_aggregator: a table of
//               single-cycle bus/input steps with expected irq and read data,
//               followed by hand-written holdoff, collision and reset
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qsys_irq_aggregator;
  import qsys_irq_pkg::*;

  localparam int NUM_IRQ = 8;

  logic               clk;
  logic               reset_n;
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [15:0]        readdata;
  logic [NUM_IRQ-1:0] irq_in;
  logic               irq;

  int n_checks;
  int n_pass;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [7:0]  in;
    logic        exp_irq;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  qsys_irq_aggregator #(
    .NUM_IRQ (NUM_IRQ),
    .DATA_W  (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge
  task automatic step(input bit wr, input bit rd, input logic [2:0] a,
                      input logic [15:0] d, input logic [7:0] in);
    address    = a;
    writedata  = d;
    chipselect = wr | rd;
    write_n    = ~wr;
    irq_in     = in;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  function automatic void add(bit wr, bit rd, logic [2:0] a, logic [15:0] d,
                              logic [7:0] in, logic ei, logic [15:0] er);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.data = d;
    v.in = in; v.exp_irq = ei; v.exp_rd = er;
    tbl.push_back(v);
  endfunction

  function automatic void w(logic [2:0] a, logic [15:0] d, logic [7:0] in, logic ei);
    add(1'b1, 1'b0, a, d, in, ei, 16'h0);
  endfunction

  function automatic void r(logic [2:0] a, logic [7:0] in, logic ei, logic [15:0] er);
    add(1'b0, 1'b1, a, 16'h0, in, ei, er);
  endfunction

  function automatic void idl(logic [7:0] in, logic ei);
    add(1'b0, 1'b0, 3'd0, 16'h0, in, ei, 16'h0);
  endfunction

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0;
    irq_in     = '0;

    // ---------------- vector table ----------------
    // Reset state of every address
    for (int a = 0; a < 8; a++) r(3'(a), 8'h00, 1'b0, 16'h0000);
    // Timer level path
    w(ADDR_MASK, 16'h0001, 8'h00, 1'b0);
    w(ADDR_EDGE, 16'h0000, 8'h00, 1'b0);
    idl(8'h01, 1'b0);
    r(ADDR_VECTOR, 8'h01, 1'b1, 16'h8000);
    r(ADDR_RAW,    8'h01, 1'b1, 16'h0001);
    idl(8'h00, 1'b1);
    idl(8'h00, 1'b0);
    r(ADDR_PENDING, 8'h00, 1'b0, 16'h0000);
    // Edge latch and ACK
    w(ADDR_EDGE, 16'h0004, 8'h00, 1'b0);
    w(ADDR_MASK, 16'h0004, 8'h00, 1'b0);
    idl(8'h04, 1'b0);
    idl(8'h00, 1'b1);
    r(ADDR_PENDING, 8'h00, 1'b1, 16'h0004);
    r(ADDR_VECTOR,  8'h00, 1'b1, 16'h8002);
    w(ADDR_VECTOR, 16'h0000, 8'h00, 1'b0);
    r(ADDR_PENDING, 8'h00, 1'b0, 16'h0000);
    // Priority: bits 5 and 3 together
    w(ADDR_MASK, 16'h00FF, 8'h00, 1'b0);
    w(ADDR_EDGE, 16'h00FF, 8'h00, 1'b0);
    idl(8'h28, 1'b0);
    idl(8'h00, 1'b1);
    r(ADDR_VECTOR, 8'h00, 1'b1, 16'h8003);
    w(ADDR_VECTOR, 16'h0000, 8'h00, 1'b1);
    r(ADDR_VECTOR, 8'h00, 1'b1, 16'h8005);
    w(ADDR_VECTOR, 16'h0000, 8'h00, 1'b0);
    r(ADDR_VECTOR, 8'h00, 1'b0, 16'h0000);
    // Edge -> level switch discards the latched bit
    idl(8'h10, 1'b0);
    idl(8'h00, 1'b1);
    w(ADDR_EDGE, 16'h00EF, 8'h00, 1'b1);
    idl(8'h00, 1'b1);
    r(ADDR_PENDING, 8'h00, 1'b0, 16'h0000);
    w(ADDR_EDGE, 16'h00FF, 8'h00, 1'b0);

    // Hold reset for a few clocks, check outputs, then release mid-cycle
    repeat (3) @(posedge clk);
    #1;
    check("reset irq", {15'b0, irq}, 16'h0000);
    check("reset readdata", readdata, 16'h0000);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].in);
      if (tbl[i].rd) check($sformatf("vec%0d readdata", i), readdata, tbl[i].exp_rd);
      check($sformatf("vec%0d irq", i), {15'b0, irq}, {15'b0, tbl[i].exp_irq});
    end

    // ---------------- holdoff window ----------------
    step(1, 0, ADDR_HOLDOFF, 16'd10, 8'h00);
    step(0, 0, 3'd0, 16'h0, 8'h06);
    step(0, 0, 3'd0, 16'h0, 8'h00);
    check("hold pre irq", {15'b0, irq}, 16'h0001);
    step(0, 1, ADDR_VECTOR, 16'h0, 8'h00);
    check("hold pre vector", readdata, 16'h8001);
    step(1, 0, ADDR_VECTOR, 16'h0, 8'h00);
    check("hold ack irq", {15'b0, irq}, 16'h0000);
    for (int k = 1; k <= 10; k++) begin
      // Rewriting HOLDOFF mid-window must not shorten it
      if (k == 3) step(1, 0, ADDR_HOLDOFF, 16'd0, 8'h00);
      else        step(0, 0, 3'd0, 16'h0, 8'h00);
      check($sformatf("hold low %0d irq", k), {15'b0, irq}, 16'h0000);
    end
    step(0, 1, ADDR_VECTOR, 16'h0, 8'h00);
    check("hold release irq", {15'b0, irq}, 16'h0001);
    check("hold release vector", readdata, 16'h8002);
    step(1, 0, ADDR_VECTOR, 16'h0, 8'h00);
    check("hold final ack irq", {15'b0, irq}, 16'h0000);

    // ---------------- W1C / new-edge collision ----------------
    step(0, 0, 3'd0, 16'h0, 8'h02);
    step(0, 0, 3'd0, 16'h0, 8'h00);
    check("coll assert irq", {15'b0, irq}, 16'h0001);
    step(1, 0, ADDR_PENDING, 16'h0002, 8'h02);
    step(0, 1, ADDR_PENDING, 16'h0, 8'h00);
    check("coll set wins", readdata, 16'h0002);
    step(1, 0, ADDR_PENDING, 16'h0002, 8'h00);
    check("coll w1c irq", {15'b0, irq}, 16'h0001);
    step(0, 1, ADDR_PENDING, 16'h0, 8'h00);
    check("w1c clears", readdata, 16'h0000);
    check("w1c irq drop", {15'b0, irq}, 16'h0000);
    // ACK with nothing pending is ignored
    step(1, 0, ADDR_HOLDOFF, 16'd5, 8'h00);
    step(1, 0, ADDR_VECTOR, 16'h0, 8'h00);
    step(0, 1, ADDR_PENDING, 16'h0, 8'h00);
    check("null ack pending", readdata, 16'h0000);
    step(0, 1, ADDR_HOLDOFF, 16'h0, 8'h00);
    check("null ack holdoff", readdata, 16'd5);
    step(0, 1, ADDR_VECTOR, 16'h0, 8'h00);
    check("null ack vector", readdata, 16'h0000);
    check("null ack irq", {15'b0, irq}, 16'h0000);

    // ---------------- reset mid-HOLD ----------------
    step(1, 0, ADDR_HOLDOFF, 16'd20, 8'h00);
    step(0, 0, 3'd0, 16'h0, 8'h01);
    step(0, 0, 3'd0, 16'h0, 8'h00);
    check("rst pre irq", {15'b0, irq}, 16'h0001);
    step(1, 0, ADDR_VECTOR, 16'h0, 8'h00);
    // cnt loaded with 19 at the ACK edge; 14 more clocks bring it to 5
    for (int k = 0; k < 14; k++) step(0, 1, ADDR_MASK, 16'h0, 8'h00);
    check("rst pre mask", readdata, 16'h00FF);
    check("rst pre hold irq", {15'b0, irq}, 16'h0000);
    #2;
    reset_n = 1'b0;
    irq_in  = 8'h01;
    #1;
    check("rst async readdata", readdata, 16'h0000);
    check("rst async irq", {15'b0, irq}, 16'h0000);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step(0, 1, ADDR_PENDING, 16'h0, 8'h01);
    check("rst pending", readdata, 16'h0000);
    step(0, 1, ADDR_MASK, 16'h0, 8'h01);
    check("rst mask", readdata, 16'h0000);
    step(0, 1, ADDR_EDGE, 16'h0, 8'h01);
    check("rst edge", readdata, 16'h0000);
    step(0, 1, ADDR_HOLDOFF, 16'h0, 8'h01);
    check("rst holdoff", readdata, 16'h0000);
    step(0, 1, ADDR_PENDING, 16'h0, 8'h01);
    check("rst level pending", readdata, 16'h0001);
    step(0, 1, ADDR_VECTOR, 16'h0, 8'h01);
    check("rst vector", readdata, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 3'd0, 16'h0, 8'h01);
      check($sformatf("rst masked irq %0d", k), {15'b0, irq}, 16'h0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
